fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: holds the 16-bit program counter and drives the instruction ROM address.
//  Captures the 9-bit ROM word into an IF/ID register (instr + pc + valid) for decode.
//  Applies stall and taken-branch redirects from downstream, and flags program completion.
// PARAMETERS
//  PC_W      16           program counter / ROM address width
//  INSTR_W   9            instruction width
//  RESET_PC  16'd0        first fetch address after start
//  PROG_LEN  16'd55       ROM depth; fetching address PROG_LEN-1 ends the program
//  NOP_INSTR 9'b000000000 word placed in if_instr_out when not valid
// PORTS
//  clk               in   1        rising-edge clock
//  rst_n             in   1        asynchronous active-low reset
//  start_in          in   1        pulse: begin fetching at RESET_PC (IDLE/DONE only)
//  stall_in          in   1        hold PC and IF/ID register this cycle
//  branch_in         in   1        taken branch/jump redirect
//  branch_target_in  in   PC_W     absolute redirect address
//  pc_out            out  PC_W     address to instruction ROM (combinational from pc reg)
//  instr_in          in   INSTR_W  ROM data for pc_out (same cycle, combinational ROM)
//  if_instr_out      out  INSTR_W  registered instruction to decode
//  if_pc_out         out  PC_W     address of if_instr_out
//  if_valid_out      out  1        if_instr_out is a real instruction
//  done_out          out  1        program finished; held until next start
//  fetch_count_out   out  PC_W     instructions issued since start (saturates at all-ones)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; pc=RESET_PC; if_instr=NOP_INSTR; if_pc=0; if_valid=0;
//   done=0; fetch_count=0. Outputs at reset values on the first edge after release.
//  FSM states IDLE, RUN, DONE.
//   IDLE: pc held at RESET_PC, if_valid=0. start_in -> RUN; fetch_count<=0.
//   RUN, per edge, priority order:
//    1 branch_in=1 (wins over stall): pc<=branch_target_in; if_instr<=NOP_INSTR; if_valid<=0
//      (squash wrong-path word). Target >= PROG_LEN -> DONE.
//    2 stall_in=1: pc, if_instr, if_pc, if_valid, fetch_count all hold.
//    3 else: if_instr<=instr_in; if_pc<=pc; if_valid<=1; fetch_count+=1 (saturating);
//      if pc==PROG_LEN-1 -> DONE (pc unchanged), else pc<=pc+1 (mod 2^PC_W).
//    start_in ignored in RUN.
//   DONE: done_out=1; if_valid<=0 and if_instr<=NOP_INSTR on the entry edge (last word
//    issued by the terminating fetch is still presented one cycle: if_valid=1 that cycle
//    only if entry was case 3). stall_in/branch_in ignored. start_in -> RUN with pc<=RESET_PC,
//    done<=0, fetch_count<=0.
//  Latency: instr at pc_out in cycle N appears on if_instr_out after edge N+1; one bubble per branch.
//  rst_n asserted mid-RUN: immediate return to reset values; no partial fetch retained.
// STRUCTURE
//  fetch_pkg: state enum {IDLE,RUN,DONE}, PC_W/INSTR_W, NOP_INSTR, RESET_PC constants.
//  One sub-module: pc_next_sel (combinational next-pc/next-state mux: branch/stall/inc/end);
//   fetch_unit keeps all flops (pc, IF/ID register, state, counter).
//  Integrates directly with instr_rom_3: pc_out -> pc_in, instr_out -> instr_in.
// TESTING
//  T1 reset, start at t0, no stall/branch, ROM stub = addr[8:0] -> if_instr 0,1,2.. with
//     if_pc 0,1,2..; done_out rises after addr 54 issued; fetch_count_out=55.
//  T2 stall_in high 3 cycles at pc=5 -> if_instr/if_pc/pc_out frozen (pc 5), count unchanged, resumes at 5.
//  T3 branch_in at pc=10, target 30 -> next if_valid=0 (NOP), then if_pc=30,31..; count excludes squashed word.
//  T4 branch_in and stall_in together at pc=12, target 2 -> branch wins; pc_out=2 next cycle.
//  T5 branch target 16'd60 (>=PROG_LEN) -> DONE, done_out=1, if_valid=0; start_in restarts at pc 0, done=0.
//  T6 rst_n low mid-RUN at pc=20 -> async: pc_out=0, if_valid=0, done=0 before next edge; start_in in RUN ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 9;

    localparam logic [PC_W-1:0]    RESET_PC  = 16'd0;
    localparam logic [PC_W-1:0]    PROG_LEN  = 16'd55;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 9'b000000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // What the IF/ID register and fetch counter do on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_ISSUE = 2'd1,
        ACT_CLEAR = 2'd2,
        ACT_START = 2'd3
    } act_e;

    function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
        return (v == '1) ? v : v + PC_W'(1);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc / next-state selection for the fetch stage; purely combinational.
module pc_next_sel
    import fetch_pkg::*;
(
    input  state_e            state_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [PC_W-1:0]   branch_target_i,
    output state_e            state_o,
    output logic [PC_W-1:0]   pc_o,
    output act_e              act_o
);

    always_comb begin
        state_o = state_i;
        pc_o    = pc_i;
        act_o   = ACT_HOLD;
        unique case (state_i)
            IDLE: begin
                pc_o  = RESET_PC;
                act_o = ACT_CLEAR;
                if (start_i) begin
                    state_o = RUN;
                    act_o   = ACT_START;
                end
            end
            RUN: begin
                // A redirect squashes the wrong-path word even when stalled.
                if (branch_i) begin
                    pc_o  = branch_target_i;
                    act_o = ACT_CLEAR;
                    if (branch_target_i >= PROG_LEN) state_o = DONE;
                end else if (!stall_i) begin
                    act_o = ACT_ISSUE;
                    if (pc_i == PROG_LEN - PC_W'(1)) state_o = DONE;
                    else                             pc_o    = pc_i + PC_W'(1);
                end
            end
            DONE: begin
                act_o = ACT_CLEAR;
                if (start_i) begin
                    state_o = RUN;
                    pc_o    = RESET_PC;
                    act_o   = ACT_START;
                end
            end
            default: begin
                state_o = IDLE;
                pc_o    = RESET_PC;
                act_o   = ACT_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID register, run/done control and fetch counter.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_in,
    input  logic               stall_in,
    input  logic               branch_in,
    input  logic [PC_W-1:0]    branch_target_in,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] if_instr_out,
    output logic [PC_W-1:0]    if_pc_out,
    output logic               if_valid_out,
    output logic               done_out,
    output logic [PC_W-1:0]    fetch_count_out,
    output logic [1:0]         dbg_state_out
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   if_instr_q;
    logic [PC_W-1:0]      if_pc_q;
    logic                 if_valid_q;
    logic                 done_q;
    logic [PC_W-1:0]      count_q;
    act_e                 act;

    pc_next_sel u_sel (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .start_i         (start_in),
        .stall_i         (stall_in),
        .branch_i        (branch_in),
        .branch_target_i (branch_target_in),
        .state_o         (state_d),
        .pc_o            (pc_d),
        .act_o           (act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            unique case (act)
                ACT_ISSUE: begin
                    if_instr_q <= instr_in;
                    if_pc_q    <= pc_q;
                    if_valid_q <= 1'b1;
                    count_q    <= sat_inc(count_q);
                end
                ACT_CLEAR: begin
                    if_instr_q <= NOP_INSTR;
                    if_valid_q <= 1'b0;
                end
                ACT_START: begin
                    if_instr_q <= NOP_INSTR;
                    if_valid_q <= 1'b0;
                    count_q    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign pc_out          = pc_q;
    assign if_instr_out    = if_instr_q;
    assign if_pc_out       = if_pc_q;
    assign if_valid_out    = if_valid_q;
    assign done_out        = done_q;
    assign fetch_count_out = count_q;
    assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM stub returns addr[8:0]; table of per-edge vectors plus hand sequences.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               start_in;
    logic               stall_in;
    logic               branch_in;
    logic [PC_W-1:0]    branch_target_in;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_in;
    logic [INSTR_W-1:0] if_instr_out;
    logic [PC_W-1:0]    if_pc_out;
    logic               if_valid_out;
    logic               done_out;
    logic [PC_W-1:0]    fetch_count_out;
    logic [1:0]         dbg_state_out;

    int n_checks;
    int n_errors;

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .stall_in         (stall_in),
        .branch_in        (branch_in),
        .branch_target_in (branch_target_in),
        .pc_out           (pc_out),
        .instr_in         (instr_in),
        .if_instr_out     (if_instr_out),
        .if_pc_out        (if_pc_out),
        .if_valid_out     (if_valid_out),
        .done_out         (done_out),
        .fetch_count_out  (fetch_count_out),
        .dbg_state_out    (dbg_state_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_in = pc_out[8:0];

    typedef struct {
        logic        start;
        logic        stall;
        logic        branch;
        logic [15:0] target;
        logic [15:0] pc;
        logic [8:0]  instr;
        logic [15:0] if_pc;
        logic        valid;
        logic        done;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic sl, input logic br, input int tg,
                                input int pc, input int ins, input int ipc, input logic v,
                                input logic d, input int c);
        vec_t r;
        r.start = st; r.stall = sl; r.branch = br; r.target = 16'(tg);
        r.pc = 16'(pc); r.instr = 9'(ins); r.if_pc = 16'(ipc);
        r.valid = v; r.done = d; r.count = 16'(c);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int pc, input int ins, input int ipc,
                           input logic v, input logic d, input int c);
        chk({nm, ".pc"},    32'(pc_out),          32'(pc));
        chk({nm, ".instr"}, 32'(if_instr_out),    32'(ins));
        chk({nm, ".if_pc"}, 32'(if_pc_out),       32'(ipc));
        chk({nm, ".valid"}, 32'(if_valid_out),    32'(v));
        chk({nm, ".done"},  32'(done_out),        32'(d));
        chk({nm, ".count"}, 32'(fetch_count_out), 32'(c));
    endtask

    // driver: apply inputs, take one edge, sample 1 time unit later
    task automatic step(input logic st, input logic sl, input logic br, input logic [15:0] tg);
        start_in = st; stall_in = sl; branch_in = br; branch_target_in = tg;
        @(posedge clk);
        #1;
        start_in = 1'b0; stall_in = 1'b0; branch_in = 1'b0; branch_target_in = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start_in = 1'b0; stall_in = 1'b0; branch_in = 1'b0; branch_target_in = '0;
        #12;
        rst_n = 1'b1;
        #1;
        chk_all("reset", 0, 0, 0, 1'b0, 1'b0, 0);
        chk("reset.state", 32'(dbg_state_out), 32'(IDLE));
        step(1'b0, 1'b0, 1'b0, '0);
        chk_all("idle_hold", 0, 0, 0, 1'b0, 1'b0, 0);

        // T1: straight-line run to the end of the program
        step(1'b1, 1'b0, 1'b0, '0);
        chk_all("t1_start", 0, 0, 0, 1'b0, 1'b0, 0);
        chk("t1_start.state", 32'(dbg_state_out), 32'(RUN));
        for (int i = 0; i < 55; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            chk_all($sformatf("t1_fetch%0d", i), (i < 54) ? i + 1 : 54, i, i, 1'b1, (i == 54), i + 1);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        chk_all("t1_done", 54, 0, 54, 1'b0, 1'b1, 55);
        chk("t1_done.state", 32'(dbg_state_out), 32'(DONE));
        step(1'b1, 1'b0, 1'b0, '0);
        chk_all("t1_restart", 0, 0, 54, 1'b0, 1'b0, 0);

        // vector table: T2 stall, T3 branch, T4 branch+stall, T5 out-of-range branch, end boundary
        for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, 0, 0, 0, k, k - 1, k - 1, 1, 0, k));
        for (int k = 0; k < 3; k++)  vecs.push_back(mk(0, 1, 0, 0, 5, 4, 4, 1, 0, 5));
        for (int k = 6; k <= 10; k++) vecs.push_back(mk(0, 0, 0, 0, k, k - 1, k - 1, 1, 0, k));
        vecs.push_back(mk(0, 0, 1, 30, 30, 0, 9, 0, 0, 10));
        vecs.push_back(mk(0, 0, 0, 0, 31, 30, 30, 1, 0, 11));
        vecs.push_back(mk(0, 0, 0, 0, 32, 31, 31, 1, 0, 12));
        vecs.push_back(mk(0, 0, 1, 12, 12, 0, 31, 0, 0, 12));
        vecs.push_back(mk(0, 1, 1, 2, 2, 0, 31, 0, 0, 12));
        vecs.push_back(mk(0, 0, 0, 0, 3, 2, 2, 1, 0, 13));
        vecs.push_back(mk(0, 0, 1, 60, 60, 0, 2, 0, 1, 13));
        vecs.push_back(mk(0, 1, 1, 5, 60, 0, 2, 0, 1, 13));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 2, 1, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 54, 54, 0, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 54, 54, 54, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 54, 0, 54, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 54, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 55, 55, 0, 54, 0, 1, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].stall, vecs[i].branch, vecs[i].target);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].if_pc,
                    vecs[i].valid, vecs[i].done, vecs[i].count);
        end

        // T6: asynchronous reset in the middle of a run
        step(1'b1, 1'b0, 1'b0, '0);
        chk_all("t6_start", 0, 0, 54, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0);
        chk_all("t6_pc20", 20, 19, 19, 1'b1, 1'b0, 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t6_async", 0, 0, 0, 1'b0, 1'b0, 0);
        chk("t6_async.state", 32'(dbg_state_out), 32'(IDLE));
        #3;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);
        chk_all("t6_after", 0, 0, 0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk_all("t6_refetch", 1, 0, 0, 1'b1, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
